// File: rtl/output_display.sv
// ----------------------------------------------------------------------------
// output_display
//
// Output-register stage that sits downstream of the CPU bus. The bus value is
// captured when the output-in line is asserted on a rising edge of the CPU
// clock. The captured value is converted to decimal by a sequential
// double-dabble engine, either as an unsigned value or as two's complement.
// The result drives a 4-digit multiplexed 7-segment display showing the sign,
// hundreds, tens and ones digits.
//
// The block runs entirely on the fast system clock. cpuClk is not used as a
// clock here: it is sampled as data and its rising edges are detected.
//
// Ports:
//   clk          fast system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   cpuClk       gated CPU clock, synchronous to clk, sampled for rising edges
//   oi           output-in control line
//   data[7:0]    CPU bus
//   signed_mode  1 = show the captured value as two's complement
//   value[7:0]   captured output register
//   busy         decimal conversion in progress
//   seg[6:0]     segments {g,f,e,d,c,b,a}, active-high
//   digit_sel    one-hot digit enable: bit0 ones, bit1 tens, bit2 hundreds,
//                bit3 sign
//
// Conversion handshake: busy rises on the cycle after a capture and falls on
// the first cycle in which the new digits are on the display. A capture while
// busy restarts the conversion; only the latest capture is ever displayed.
// ----------------------------------------------------------------------------
module output_display #(
    parameter int REFRESH_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpuClk,
    input  logic       oi,
    input  logic [7:0] data,
    input  logic       signed_mode,
    output logic [7:0] value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] digit_sel
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic          r_cpu_clk_q;
    logic [7:0]    r_value;
    state_t        r_state;
    logic          r_busy;
    logic [7:0]    r_mag;
    logic [11:0]   r_bcd;
    logic [2:0]    r_shift_cnt;
    logic          r_neg_pend;
    logic [3:0]    r_hun;
    logic [3:0]    r_ten;
    logic [3:0]    r_one;
    logic          r_neg;
    logic [CW-1:0] r_refresh_cnt;
    logic [1:0]    r_digit_idx;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_rise;
    logic        w_capture;
    logic        w_neg;
    logic [7:0]  w_mag;
    logic [11:0] w_bcd_adj;
    logic [19:0] w_shifted;

    assign w_rise    = cpuClk & ~r_cpu_clk_q;
    assign w_capture = w_rise & oi;

    // Negative two's-complement values are converted as their magnitude.
    // 8'h80 negates to itself, which read as unsigned is the required 128.
    assign w_neg = signed_mode & data[7];
    assign w_mag = w_neg ? (~data + 8'd1) : data;

    // Double-dabble step: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    assign w_shifted = {w_bcd_adj, r_mag} << 1;

    // ------------------------------------------------------------------
    // Capture and conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cpu_clk_q <= 1'b0;
            r_value     <= 8'd0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_mag       <= 8'd0;
            r_bcd       <= 12'd0;
            r_shift_cnt <= 3'd0;
            r_neg_pend  <= 1'b0;
            r_hun       <= 4'd0;
            r_ten       <= 4'd0;
            r_one       <= 4'd0;
            r_neg       <= 1'b0;
        end else begin
            r_cpu_clk_q <= cpuClk;
            // A capture always wins, including over a conversion in flight:
            // the engine restarts and the aborted result is dropped.
            if (w_capture) begin
                r_value     <= data;
                r_mag       <= w_mag;
                r_neg_pend  <= w_neg;
                r_bcd       <= 12'd0;
                r_shift_cnt <= 3'd0;
                r_busy      <= 1'b1;
                r_state     <= S_SHIFT;
            end else begin
                case (r_state)
                    S_SHIFT: begin
                        r_bcd       <= w_shifted[19:8];
                        r_mag       <= w_shifted[7:0];
                        r_shift_cnt <= r_shift_cnt + 3'd1;
                        if (r_shift_cnt == 3'd7) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        r_hun   <= r_bcd[11:8];
                        r_ten   <= r_bcd[7:4];
                        r_one   <= r_bcd[3:0];
                        r_neg   <= r_neg_pend;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Display refresh: free-running, independent of the conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= 2'd0;
        end else begin
            if (r_refresh_cnt == REFRESH_LAST) begin
                r_refresh_cnt <= '0;
                r_digit_idx   <= r_digit_idx + 2'd1;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment encoding
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Leading zeros are blanked; the ones digit is always lit.
    always_comb begin
        seg = 7'h00;
        case (r_digit_idx)
            2'd0: seg = seg7(r_one);
            2'd1: seg = (r_hun == 4'd0 && r_ten == 4'd0) ? 7'h00 : seg7(r_ten);
            2'd2: seg = (r_hun == 4'd0) ? 7'h00 : seg7(r_hun);
            2'd3: seg = r_neg ? 7'h40 : 7'h00;
            default: seg = 7'h00;
        endcase
    end

    assign digit_sel = 4'b0001 << r_digit_idx;
    assign value     = r_value;
    assign busy      = r_busy;

endmodule
